// File: rtl/ack_retransmit_ctrl.sv
// Alternating-bit ACK/retransmit controller: sends a packet, waits for a matching ACK,
// retransmits on timeout up to MAX_RETRIES times, then latches a link error until cleared.
module ack_retransmit_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       update_data,
    input  logic       send_done,
    input  logic       ack_received,
    input  logic       ack_seqNum,
    input  logic       clear_error,
    output logic       send_data,
    output logic       sender_seqNum,
    output logic [3:0] retry_count,
    output logic [3:0] acks_ok_cnt,
    output logic       busy,
    output logic       link_error
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] MaxRetries = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {StIdle, StSend, StWaitDone, StWaitAck, StError} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              pending_q, pending_d;
    logic              seq_q, seq_d;
    logic [3:0]        retry_q, retry_d;
    logic [3:0]        acks_q, acks_d;
    logic              ack_match;
    logic              timeout;

    assign ack_match = ack_received && (ack_seqNum == seq_q);
    assign timeout   = (timer_q == TimerLast);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            pending_q <= 1'b0;
            seq_q     <= 1'b0;
            retry_q   <= '0;
            acks_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            retry_q   <= retry_d;
            acks_q    <= acks_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (update_data || pending_q) state_d = StSend;
            StSend:     state_d = StWaitDone;
            StWaitDone: if (send_done) state_d = StWaitAck;
            StWaitAck: begin
                // A matching ACK wins over a timeout landing on the same cycle.
                if (ack_match) begin
                    state_d = StIdle;
                end else if (timeout) begin
                    state_d = (retry_q < MaxRetries) ? StSend : StError;
                end
            end
            StError:    if (clear_error) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        timer_d   = timer_q;
        pending_d = pending_q;
        seq_d     = seq_q;
        retry_d   = retry_q;
        acks_d    = acks_q;

        // Requests arriving while busy collapse into a single deferred send.
        if (state_q == StIdle) begin
            pending_d = 1'b0;
        end else if (update_data) begin
            pending_d = 1'b1;
        end

        if (state_q == StWaitDone && send_done) begin
            timer_d = '0;
        end

        if (state_q == StWaitAck) begin
            if (ack_match) begin
                seq_d   = ~seq_q;
                acks_d  = acks_q + 4'd1;
                retry_d = '0;
            end else if (timeout) begin
                if (retry_q < MaxRetries) retry_d = retry_q + 4'd1;
            end else begin
                timer_d = timer_q + TimerW'(1);
            end
        end

        if (state_q == StError && clear_error) begin
            retry_d   = '0;
            pending_d = 1'b0;
        end
    end

    always_comb begin
        send_data  = (state_q == StSend);
        busy       = (state_q != StIdle);
        link_error = (state_q == StError);
    end

    assign sender_seqNum = seq_q;
    assign retry_count   = retry_q;
    assign acks_ok_cnt   = acks_q;

endmodule
